// File: rtl/game_timer_bcd_if.sv
// ============================================================================
// Module      : game_timer_bcd_if
// Description : Control/status bundle between the game FSM and the BCD
//               countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_timer_bcd_if #(
   parameter int NUM_DIGITS = 2
);
   logic                    enable;
   logic                    pause;
   logic                    restart;
   logic                    load_en;
   logic [NUM_DIGITS*4-1:0] load_bcd;
   logic [NUM_DIGITS*7-1:0] time_ascii;
   logic                    tick;
   logic                    running;
   logic                    timer_done;
   logic                    warn;

   modport master (
      output enable, pause, restart, load_en, load_bcd,
      input  time_ascii, tick, running, timer_done, warn
   );

   modport slave (
      input  enable, pause, restart, load_en, load_bcd,
      output time_ascii, tick, running, timer_done, warn
   );
endinterface

`default_nettype wire

// File: rtl/game_timer_bcd.sv
// ============================================================================
// Module      : game_timer_bcd
// Description : N-digit BCD countdown game timer with prescaled tick and
//               ASCII digit output. Optional macro: GAME_TIMER_WARN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer_bcd #(
   parameter int          NUM_DIGITS = 2,
   parameter logic [15:0] START_BCD  = 16'h0031,
   parameter int          TICK_DIV   = 100000000,
   parameter logic [15:0] WARN_BCD   = 16'h0005
) (
   input  wire logic        clk,
   input  wire logic        rst,
   game_timer_bcd_if.slave  bus
);

   localparam int W  = NUM_DIGITS * 4;
   localparam int AW = NUM_DIGITS * 7;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Ripple borrow from the least significant digit; callers never pass zero.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [AW-1:0] to_ascii(input logic [W-1:0] v);
      logic [AW-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[i*7 +: 7] = 7'h30 + {3'b000, v[i*4 +: 4]};
      end
      return r;
   endfunction

   localparam logic [W-1:0]  START_INIT = START_BCD[W-1:0];
   localparam logic [AW-1:0] ASCII_INIT = to_ascii(START_INIT);

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   start_q, start_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic           tick_q, tick_d;
   logic [AW-1:0]  ascii_q, ascii_d;
   logic [W-1:0]   load_clamped;
   logic [W-1:0]   idle_count;
   logic [W-1:0]   dec_count;

   assign load_clamped = bcd_clamp(bus.load_bcd);
   assign idle_count   = bus.load_en ? load_clamped : count_q;
   assign dec_count    = bcd_dec(count_q);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      start_d = start_q;
      presc_d = presc_q;
      tick_d  = 1'b0;

      if (bus.load_en) start_d = load_clamped;

      if (bus.restart) begin
         count_d = bus.load_en ? load_clamped : start_q;
         presc_d = '0;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_d = idle_count;
               if (bus.enable) begin
                  if (idle_count == '0) begin
                     state_d = ST_DONE;
                  end else if (!bus.pause) begin
                     state_d = ST_RUNNING;
                     presc_d = '0;
                  end
               end
            end
            // Resuming from pause counts as a running cycle so no prescale is lost.
            ST_RUNNING, ST_PAUSED: begin
               if (!bus.enable || bus.pause) begin
                  state_d = ST_PAUSED;
               end else begin
                  state_d = ST_RUNNING;
                  if (presc_q == PMAX) begin
                     presc_d = '0;
                     if (count_q != '0) begin
                        tick_d  = 1'b1;
                        count_d = dec_count;
                        if (dec_count == '0) state_d = ST_DONE;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
            end
            ST_DONE: begin
               if (bus.load_en) begin
                  count_d = load_clamped;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign ascii_d = to_ascii(count_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= START_INIT;
         start_q <= START_INIT;
         presc_q <= '0;
         tick_q  <= 1'b0;
         ascii_q <= ASCII_INIT;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         start_q <= start_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         ascii_q <= ascii_d;
      end
   end

   assign bus.time_ascii = ascii_q;
   assign bus.tick       = tick_q;
   assign bus.running    = (state_q == ST_RUNNING);
   assign bus.timer_done = (state_q == ST_DONE);

`ifdef GAME_TIMER_WARN_EN
   logic warn_q, warn_d;

   // Packed valid BCD orders the same as binary, so a plain compare suffices.
   assign warn_d = ((state_d == ST_RUNNING) || (state_d == ST_PAUSED)) &&
                   (count_d <= WARN_BCD[W-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) warn_q <= 1'b0;
      else     warn_q <= warn_d;
   end

   assign bus.warn = warn_q;
`else
   logic warn_param_unused;
   assign warn_param_unused = ^WARN_BCD;
   assign bus.warn          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_timer_bcd.sv
// ============================================================================
// Module      : tb_game_timer_bcd
// Description : Self-checking bench for game_timer_bcd (2 digits, TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_timer_bcd;

   localparam int TICK_DIV = 4;
`ifdef GAME_TIMER_WARN_EN
   localparam bit WARN_ON = 1'b1;
`else
   localparam bit WARN_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nbad = 0;
   int   mv   = 31;

   always #5 clk = ~clk;

   game_timer_bcd_if #(.NUM_DIGITS(2)) bus ();

   game_timer_bcd #(
      .NUM_DIGITS (2),
      .START_BCD  (16'h0031),
      .TICK_DIV   (TICK_DIV),
      .WARN_BCD   (16'h0005)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic       en, pa, rs, ld;
      logic [7:0] lb;
      int         val;
      logic       tk, run, done, wrn;
   } vec_t;

   vec_t tbl [18];

   function automatic logic [13:0] asc(input int v);
      return {7'(7'h30 + v / 10), 7'(7'h30 + v % 10)};
   endfunction

   task automatic chk(input string nm, input int ev, input logic et, er, ed, ew);
      logic [13:0] ea;
      logic        ewm;
      ea  = asc(ev);
      ewm = ew & WARN_ON;
      nvec++;
      if (bus.time_ascii !== ea || bus.tick !== et || bus.running !== er ||
          bus.timer_done !== ed || bus.warn !== ewm) begin
         nbad++;
         $display("FAIL %s: got ascii=%h tick=%b run=%b done=%b warn=%b, want ascii=%h tick=%b run=%b done=%b warn=%b",
                  nm, bus.time_ascii, bus.tick, bus.running, bus.timer_done, bus.warn,
                  ea, et, er, ed, ewm);
      end
   endtask

   task automatic step(input logic en, pa, rs, ld, input logic [7:0] lb);
      bus.enable   = en;
      bus.pause    = pa;
      bus.restart  = rs;
      bus.load_en  = ld;
      bus.load_bcd = lb;
      @(posedge clk);
      #1;
   endtask

   // Runs enabled until the model count reaches target, checking each tick and its spacing.
   task automatic run_until(input int target, input int first_gap);
      int gap;
      int want_gap;
      int steps;
      gap      = 0;
      want_gap = first_gap;
      steps    = 0;
      while (mv > target && steps < 400) begin
         step(1, 0, 0, 0, 8'h00);
         steps++;
         gap++;
         if (bus.tick === 1'b1) begin
            mv--;
            nvec++;
            if (gap != want_gap) begin
               nbad++;
               $display("FAIL tick_gap: got %0d cycles, want %0d (count %0d)", gap, want_gap, mv);
            end
            chk("tick", mv, 1'b1, mv != 0, mv == 0, (mv <= 5) && (mv != 0));
            gap      = 0;
            want_gap = TICK_DIV;
         end
      end
      if (mv > target) begin
         nvec++;
         nbad++;
         $display("FAIL run_timeout: got count %0d still pending, want %0d", mv, target);
         mv = target;
      end
   endtask

   initial begin
      bus.enable   = 1'b0;
      bus.pause    = 1'b0;
      bus.restart  = 1'b0;
      bus.load_en  = 1'b0;
      bus.load_bcd = 8'h00;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 10, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  9, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hAF, 99, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00,  0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00,  0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h31, 31, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00,  0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05,  5, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  5, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h42,  5, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 42, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset", 31, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].en, tbl[i].pa, tbl[i].rs, tbl[i].ld, tbl[i].lb);
         chk($sformatf("vec%0d", i), tbl[i].val, tbl[i].tk, tbl[i].run, tbl[i].done, tbl[i].wrn);
      end

      // Full countdown from 31 to done, then no further ticks.
      step(0, 0, 1, 1, 8'h31);
      mv = 31;
      chk("reload31", 31, 1'b0, 1'b0, 1'b0, 1'b0);
      run_until(0, TICK_DIV + 1);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 0, 0, 8'h00);
         chk("done_hold", 0, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Pause at prescaler 2 for ten cycles; tick follows two cycles after release.
      step(0, 0, 1, 1, 8'h31);
      chk("restart_done", 31, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 0, 8'h00);
         chk("paused", 31, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      step(1, 0, 0, 0, 8'h00);
      chk("resume1", 31, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1, 0, 0, 0, 8'h00);
      chk("resume_tick", 30, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 0, 8'h00);
      step(1, 1, 0, 0, 8'h00);
      chk("pause_on_tick", 30, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1, 0, 0, 0, 8'h00);
      chk("tick_after_pause", 29, 1'b1, 1'b1, 1'b0, 1'b0);

      // Restart while running at 17 with a new start value loaded mid-run.
      step(0, 0, 1, 1, 8'h17);
      step(1, 0, 0, 0, 8'h00);
      step(1, 0, 0, 1, 8'h31);
      chk("load_running", 17, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1, 0, 1, 0, 8'h00);
      chk("restart_run", 31, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-count.
      step(0, 0, 1, 1, 8'h20);
      mv = 20;
      run_until(19, TICK_DIV + 1);
      step(1, 0, 0, 0, 8'h00);
      rst = 1'b1;
      #2;
      chk("async_rst", 31, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Warning window: rises at 05, holds while paused at 03, clears at done.
      step(0, 0, 1, 1, 8'h07);
      mv = 7;
      run_until(3, TICK_DIV + 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 0, 8'h00);
         chk("warn_paused", 3, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      run_until(0, TICK_DIV);
      step(1, 0, 0, 0, 8'h00);
      chk("warn_done", 0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

`default_nettype wire
